// File: rtl/weight_pkg.sv
// -----------------------------------------------------------------------------
// weight_pkg
//
// Shared definitions for the weight bank writer:
//   - DATA_W      : width of every weight word (32)
//   - state_e     : load FSM states
//   - kern_total  : number of kernel words in an image
//   - coeff_index : flat word index of the MACC coefficient
//   - clog2_min1  : index width helper that never returns 0
//
// The flat image layout is kernels first, then biases, then the single
// coefficient word. The bias region starts at kern_total().
// -----------------------------------------------------------------------------
package weight_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KERN  = 3'd1,
        ST_BIAS  = 3'd2,
        ST_COEFF = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Number of kernel words spread across all banks.
    function automatic int unsigned kern_total(input int unsigned num_banks,
                                               input int unsigned words_per_bank);
        return num_banks * words_per_bank;
    endfunction

    // Flat index of the coefficient word (last word of the image).
    function automatic int unsigned coeff_index(input int unsigned num_banks,
                                                input int unsigned words_per_bank,
                                                input int unsigned num_bias);
        return kern_total(num_banks, words_per_bank) + num_bias;
    endfunction

    // Width of an index over n items; a one-item range still gets one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_row_counter.sv
// -----------------------------------------------------------------------------
// bank_row_counter
//
// Round-robin bank selector with a row counter behind it. Each increment
// advances bank_sel; when bank_sel wraps from NUM_BANKS-1 to 0 the row
// advances. last_o flags the final (bank, row) slot of the kernel region.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   clr_i      in   synchronous clear (reload)
//   inc_i      in   advance one slot
//   bank_sel_o out  current bank
//   row_o      out  current row within the bank
//   last_o     out  current slot is the last kernel slot
// -----------------------------------------------------------------------------
module bank_row_counter
    import weight_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int ROWS      = 24918,
    parameter int BANK_W    = 2,
    parameter int ROW_W     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [BANK_W-1:0] bank_sel_o,
    output logic [ROW_W-1:0]  row_o,
    output logic              last_o
);

    logic [BANK_W-1:0] bank_q;
    logic [ROW_W-1:0]  row_q;
    logic              bank_wrap;
    logic              row_wrap;

    assign bank_wrap = (bank_q == BANK_W'(NUM_BANKS - 1));
    assign row_wrap  = (row_q == ROW_W'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            bank_q <= '0;
            row_q  <= '0;
        end else if (inc_i) begin
            if (bank_wrap) begin
                bank_q <= '0;
                row_q  <= row_wrap ? '0 : row_q + ROW_W'(1);
            end else begin
                bank_q <= bank_q + BANK_W'(1);
            end
        end
    end

    assign bank_sel_o = bank_q;
    assign row_o      = row_q;
    assign last_o     = bank_wrap && row_wrap;

endmodule

// File: rtl/weight_bank_writer.sv
// -----------------------------------------------------------------------------
// weight_bank_writer
//
// Consumes the loader's flat weight write stream and scatters it into
// NUM_BANKS interleaved kernel banks, a bias register file and the MACC
// coefficient register. weights_ready rises once the whole image is in.
//
// Build option: WEIGHT_BANK_ADDR_CHECK_EN
//   defined   - every incoming address must equal the running word count;
//               a mismatch drops the word and parks the FSM in ST_ERR.
//   undefined - addresses are ignored; words are placed by arrival order.
//
// Ports:
//   clk               in   sole clock
//   rst               in   synchronous active-high reset
//   weight_wr_en      in   write strobe from loader (no backpressure)
//   weight_wr_addr    in   flat word index
//   weight_wr_data    in   word
//   reload            in   pulse: drop progress, wait for a new image
//   kern_wr_en        out  one-hot bank write strobe, one cycle per word
//   kern_wr_addr      out  bank row
//   kern_wr_data      out  kernel word
//   bias_data         out  flattened bias registers, bias 0 in the LSBs
//   macc_coeff        out  coefficient register
//   weights_ready     out  full image loaded
//   load_err          out  sticky error (address mismatch or overflow)
//   dbg_state         out  current FSM state (state_e encoding)
//   dbg_addr_mismatch out  incoming address differs from the word count
//
// Handshake: a word is taken on every cycle weight_wr_en is high; there is
// no ready. All outputs are registered, so a write in cycle N shows up in
// N+1. reload has priority over a write in the same cycle.
// -----------------------------------------------------------------------------
module weight_bank_writer
    import weight_pkg::*;
#(
    parameter int NUM_BANKS             = 4,
    parameter int KERNEL_WORDS_PER_BANK = 24918,
    parameter int NUM_BIAS              = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     weight_wr_en,
    input  logic [31:0]                              weight_wr_addr,
    input  logic [31:0]                              weight_wr_data,
    input  logic                                     reload,
    output logic [NUM_BANKS-1:0]                     kern_wr_en,
    output logic [$clog2(KERNEL_WORDS_PER_BANK)-1:0] kern_wr_addr,
    output logic [31:0]                              kern_wr_data,
    output logic [32*NUM_BIAS-1:0]                   bias_data,
    output logic [31:0]                              macc_coeff,
    output logic                                     weights_ready,
    output logic                                     load_err,
    output logic [2:0]                               dbg_state,
    output logic                                     dbg_addr_mismatch
);

    localparam int ROW_W  = $clog2(KERNEL_WORDS_PER_BANK);
    localparam int BANK_W = clog2_min1(NUM_BANKS);
    localparam int BIAS_W = clog2_min1(NUM_BIAS);

    localparam int unsigned KERN_TOTAL = kern_total(NUM_BANKS, KERNEL_WORDS_PER_BANK);
    localparam int unsigned COEFF_IDX  = coeff_index(NUM_BANKS, KERNEL_WORDS_PER_BANK,
                                                     NUM_BIAS);
    // Word count of the final bias word; the next word is the coefficient.
    localparam logic [31:0] BIAS_LAST  = 32'(COEFF_IDX - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                          state_q;
    logic [31:0]                     word_cnt_q;
    logic [BIAS_W-1:0]               bias_idx_q;
    logic [NUM_BANKS-1:0]            kern_wr_en_q;
    logic [ROW_W-1:0]                kern_wr_addr_q;
    logic [DATA_W-1:0]               kern_wr_data_q;
    logic [NUM_BIAS-1:0][DATA_W-1:0] bias_q;
    logic [DATA_W-1:0]               coeff_q;
    logic                            ready_q;
    logic                            err_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                 addr_mismatch;
    logic                 addr_ok;
    logic                 wr_take;
    logic                 in_kern;
    logic                 kern_accept;
    logic [BANK_W-1:0]    bank_sel;
    logic [ROW_W-1:0]     row;
    logic                 kern_last;
    logic [NUM_BANKS-1:0] bank_onehot;

    assign addr_mismatch = (weight_wr_addr != word_cnt_q);

`ifdef WEIGHT_BANK_ADDR_CHECK_EN
    assign addr_ok = !addr_mismatch;
`else
    assign addr_ok = 1'b1;
`endif

    // A write only counts when reload is not pulling the rug out this cycle.
    assign wr_take     = weight_wr_en && !reload;
    assign in_kern     = (state_q == ST_IDLE) || (state_q == ST_KERN);
    assign kern_accept = wr_take && in_kern && addr_ok;

    always_comb begin
        bank_onehot = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_onehot[i] = (bank_sel == BANK_W'(i));
        end
    end

    bank_row_counter #(
        .NUM_BANKS (NUM_BANKS),
        .ROWS      (KERNEL_WORDS_PER_BANK),
        .BANK_W    (BANK_W),
        .ROW_W     (ROW_W)
    ) u_bank_row_counter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (reload),
        .inc_i      (kern_accept),
        .bank_sel_o (bank_sel),
        .row_o      (row),
        .last_o     (kern_last)
    );

    // ------------------------------------------------------------------
    // Load FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            word_cnt_q     <= '0;
            bias_idx_q     <= '0;
            kern_wr_en_q   <= '0;
            kern_wr_addr_q <= '0;
            kern_wr_data_q <= '0;
            bias_q         <= '0;
            coeff_q        <= '0;
            ready_q        <= 1'b0;
            err_q          <= 1'b0;
        end else if (reload) begin
            // Bias and coefficient contents survive a reload; they are
            // simply overwritten by the next image.
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            bias_idx_q   <= '0;
            kern_wr_en_q <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            kern_wr_en_q <= '0;
            case (state_q)
                ST_IDLE, ST_KERN: begin
                    if (weight_wr_en) begin
                        if (!addr_ok) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            kern_wr_en_q   <= bank_onehot;
                            kern_wr_addr_q <= row;
                            kern_wr_data_q <= weight_wr_data;
                            word_cnt_q     <= word_cnt_q + 32'd1;
                            state_q        <= kern_last ? ST_BIAS : ST_KERN;
                        end
                    end
                end
                ST_BIAS: begin
                    if (weight_wr_en) begin
                        if (!addr_ok) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            bias_q[bias_idx_q] <= weight_wr_data;
                            bias_idx_q         <= bias_idx_q + BIAS_W'(1);
                            word_cnt_q         <= word_cnt_q + 32'd1;
                            if (word_cnt_q == BIAS_LAST) begin
                                state_q <= ST_COEFF;
                            end
                        end
                    end
                end
                ST_COEFF: begin
                    if (weight_wr_en) begin
                        if (!addr_ok) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            coeff_q    <= weight_wr_data;
                            ready_q    <= 1'b1;
                            word_cnt_q <= word_cnt_q + 32'd1;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Image already complete: extra words are an overflow.
                    if (weight_wr_en) begin
                        err_q <= 1'b1;
                    end
                end
                ST_ERR: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_ERR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign kern_wr_en        = kern_wr_en_q;
    assign kern_wr_addr      = kern_wr_addr_q;
    assign kern_wr_data      = kern_wr_data_q;
    assign bias_data         = bias_q;
    assign macc_coeff        = coeff_q;
    assign weights_ready     = ready_q;
    assign load_err          = err_q;
    assign dbg_state         = state_q;
    // Useful on a scope even when the check is compiled out: shows the
    // loader drifting from the expected word order.
    assign dbg_addr_mismatch = weight_wr_en && addr_mismatch && (KERN_TOTAL != 0);

endmodule

// File: doc/weight_bank_writer.md
# weight_bank_writer

Downstream stage of the AXI weight loader: consumes its flat `weight_wr_en/addr/data` write stream and scatters words into NUM_BANKS parallel kernel SRAM banks, a bias register file and the MACC coefficient register. Signals `weights_ready` to the model once the full image (kernels, then biases, then coefficient) has landed. Sits between the loader and the convolution datapath's weight memories.

## Interface
- `NUM_BANKS`, 4: kernel banks, round-robin interleaved.
- `KERNEL_WORDS_PER_BANK`, 24918: rows per bank (NUM_BANKS × this = 99672 kernel words).
- `NUM_BIAS`, 4: bias words following the kernels.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `weight_wr_en`  in  1  write strobe from loader.
- `weight_wr_addr`  in  32  flat word index.
- `weight_wr_data`  in  32  word.
- `reload`  in  1  pulse: discard state, await new image.
- `kern_wr_en`  out  NUM_BANKS  one-hot bank write strobe.
- `kern_wr_addr`  out  $clog2(KERNEL_WORDS_PER_BANK)  bank row.
- `kern_wr_data`  out  32  kernel word.
- `bias_data`  out  32×NUM_BIAS  flattened bias registers, bias 0 in LSBs.
- `macc_coeff`  out  32  coefficient register.
- `weights_ready`  out  1  full image loaded.
- `load_err`  out  1  sticky: address mismatch or overflow.

## Operation
- FSM states: IDLE, KERN, BIAS, COEFF, DONE, ERR.
- IDLE → KERN on first `weight_wr_en`; that word is processed as kernel word 0.
- KERN: word goes to bank `bank_sel`, row `row`; `bank_sel` increments, wrapping at NUM_BANKS; on wrap `row` increments. After word NUM_BANKS×KERNEL_WORDS_PER_BANK−1 → BIAS.
- BIAS: word stored in `bias[bias_idx]`, `bias_idx` increments; after NUM_BIAS words → COEFF.
- COEFF: next word stored in `macc_coeff`; → DONE; `weights_ready` = 1.
- DONE: further `weight_wr_en` ignored (no bank writes), sets `load_err`; stays DONE.
- ERR: all writes ignored, `weights_ready` = 0, `load_err` = 1; exit only via `reload` or `rst`.
- `reload` (any state): → IDLE, counters, `bank_sel`, `row`, `bias_idx` cleared, `weights_ready` and `load_err` cleared; bias/coeff contents retained until overwritten. `reload` and `weight_wr_en` in the same cycle: reload wins, write dropped.
- Expected flat address = running word count (0…total−1), 32-bit counter.

## Timing
- Reset values: `kern_wr_en` 0, `kern_wr_addr` 0, `kern_wr_data` 0, `bias_data` 0, `macc_coeff` 0, `weights_ready` 0, `load_err` 0; state IDLE.
- All outputs registered: input write in cycle N → `kern_wr_*` or bias/coeff update visible in N+1.
- `kern_wr_en` is a single-cycle strobe per accepted kernel word; never more than one bit set.
- `weights_ready` rises in the same cycle `macc_coeff` shows the coefficient; held until `reload`/`rst`.
- Back-to-back writes every cycle supported; no backpressure (loader has no ready input here).
- `rst` mid-load: everything returns to reset values next edge, including bias/coeff.

## Configuration
- `WEIGHT_BANK_ADDR_CHECK_EN` defined: each incoming `weight_wr_addr` is compared to the expected word count; mismatch → write dropped, state ERR, `load_err` = 1 next cycle.
- Undefined: `weight_wr_addr` ignored, words placed purely by arrival order; `load_err` only from post-DONE overflow.

## Structure
- Package `weight_pkg`: state enum, region boundary constants (kernel word total, bias start, coeff index) derived from the parameters, data width 32.
- Sub-module `bank_row_counter`: round-robin `bank_sel` + `row` counter with clear/increment and terminal flag; instanced once.

## Test plan
(Bench parameters NUM_BANKS=2, KERNEL_WORDS_PER_BANK=3, NUM_BIAS=2; total 9 words.)
- Write addr 0…8, data 0x100+addr, one per cycle → banks get {b0: r0=0x100,r1=0x102,r2=0x104}, {b1: r0=0x101,r1=0x103,r2=0x105}; bias = {0x107,0x106}; coeff 0x108; `weights_ready` high cycle after word 8.
- Same load with gaps of 3 idle cycles between words → identical memory contents and `weights_ready` timing relative to last word.
- Tenth write after DONE → no `kern_wr_en`, `load_err` = 1, `weights_ready` stays 1.
- With `WEIGHT_BANK_ADDR_CHECK_EN`: addr sequence 0,1,5 → third write dropped, ERR, `load_err` = 1, `weights_ready` never rises; then `reload`, full correct load → ready, `load_err` 0.
- `reload` asserted together with word 4 mid-load → word 4 dropped, state IDLE; subsequent 0…8 load completes correctly.
- `rst` during BIAS → all outputs zero next cycle; fresh load succeeds.
